// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared RV32 opcodes and hazard FSM encodings
package hazard_ctrl_pkg;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_REDIRECT = 2'd1,
    HZ_MEM_WAIT = 2'd2
  } hz_state_e;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side hazard inputs and hold/flush controls
interface hazard_ctrl_if;
  logic [6:0]  opcode_ex;
  logic [4:0]  rd_addr_ex;
  logic [4:0]  rs1_addr_id;
  logic [4:0]  rs2_addr_id;
  logic        rs1_used_id;
  logic        rs2_used_id;
  logic        branch_taken_ex;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_hold;
  logic        if_id_hold;
  logic        id_ex_hold;
  logic        ex_mem_hold;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        mem_wb_flush;
  logic        mem_err;
  logic [1:0]  state;
  logic [31:0] stall_cycles;
  modport master (
    output opcode_ex, rd_addr_ex, rs1_addr_id, rs2_addr_id, rs1_used_id, rs2_used_id,
           branch_taken_ex, mem_req, mem_ready,
    input  pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, if_id_flush, id_ex_flush,
           mem_wb_flush, mem_err, state, stall_cycles
  );
  modport slave (
    input  opcode_ex, rd_addr_ex, rs1_addr_id, rs2_addr_id, rs1_used_id, rs2_used_id,
           branch_taken_ex, mem_req, mem_ready,
    output pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, if_id_flush, id_ex_flush,
           mem_wb_flush, mem_err, state, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl_load_use_detect.sv
// hazard_ctrl_load_use_detect: flags an ID source operand produced by a load still in EX
module hazard_ctrl_load_use_detect
  import hazard_ctrl_pkg::*;
(
  input  logic [6:0] opcode_ex,
  input  logic [4:0] rd_addr_ex,
  input  logic [4:0] rs1_addr_id,
  input  logic [4:0] rs2_addr_id,
  input  logic       rs1_used_id,
  input  logic       rs2_used_id,
  output logic       hazard
);
  assign hazard = opcode_ex == OPC_LOAD && rd_addr_ex != 5'd0 &&
                  ((rs1_used_id && rs1_addr_id == rd_addr_ex) ||
                   (rs2_used_id && rs2_addr_id == rd_addr_ex));
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: per-cycle hold/flush control for load-use, redirects and memory wait states
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REDIRECT_CYCLES = 1,
  parameter int MEM_TIMEOUT     = 255
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave bus
);
  localparam logic [2:0]  RED_INIT = 3'(REDIRECT_CYCLES);
  localparam logic [15:0] WAIT_MAX = 16'(MEM_TIMEOUT);
  hz_state_e   state_q, state_d;
  logic [2:0]  red_cnt_q, red_cnt_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        mem_err_q, mem_err_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic        load_use, mem_stall;
  logic        pc_hold, if_id_hold, id_ex_hold, ex_mem_hold;
  logic        if_id_flush, id_ex_flush, mem_wb_flush;
  hazard_ctrl_load_use_detect u_load_use_detect (
    .opcode_ex  (bus.opcode_ex),
    .rd_addr_ex (bus.rd_addr_ex),
    .rs1_addr_id(bus.rs1_addr_id),
    .rs2_addr_id(bus.rs2_addr_id),
    .rs1_used_id(bus.rs1_used_id),
    .rs2_used_id(bus.rs2_used_id),
    .hazard     (load_use)
  );
  // next state, counters and hold/flush decode; memory stall outranks redirect outranks load-use
  always_comb begin
    state_d      = HZ_RUN;
    red_cnt_d    = 3'd0;
    wait_cnt_d   = 16'd0;
    mem_err_d    = mem_err_q;
    mem_stall    = 1'b0;
    pc_hold      = 1'b0;
    if_id_hold   = 1'b0;
    id_ex_hold   = 1'b0;
    ex_mem_hold  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    case (state_q)
      HZ_RUN: begin
        if (bus.mem_req && !bus.mem_ready) begin
          mem_stall = 1'b1;
          state_d   = HZ_MEM_WAIT;
        end else if (bus.branch_taken_ex) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          red_cnt_d   = RED_INIT;
          state_d     = RED_INIT != 3'd0 ? HZ_REDIRECT : HZ_RUN;
        end else if (load_use) begin
          pc_hold     = 1'b1;
          if_id_hold  = 1'b1;
          id_ex_flush = 1'b1;
        end
      end
      HZ_REDIRECT: begin
        if_id_flush = 1'b1;
        if (bus.mem_req && !bus.mem_ready) begin
          mem_stall = 1'b1;
          state_d   = HZ_MEM_WAIT;
        end else if (bus.branch_taken_ex) begin
          id_ex_flush = 1'b1;
          red_cnt_d   = RED_INIT;
          state_d     = HZ_REDIRECT;
        end else begin
          red_cnt_d = red_cnt_q - 3'd1;
          state_d   = red_cnt_d != 3'd0 ? HZ_REDIRECT : HZ_RUN;
        end
      end
      HZ_MEM_WAIT: begin
        mem_stall = !bus.mem_ready;
        state_d   = bus.mem_ready ? HZ_RUN : HZ_MEM_WAIT;
      end
      default: state_d = HZ_RUN;
    endcase
    if (mem_stall) begin
      pc_hold      = 1'b1;
      if_id_hold   = 1'b1;
      id_ex_hold   = 1'b1;
      ex_mem_hold  = 1'b1;
      mem_wb_flush = 1'b1;
      wait_cnt_d   = wait_cnt_q == WAIT_MAX ? wait_cnt_q : wait_cnt_q + 16'd1;
      mem_err_d    = mem_err_q || wait_cnt_d == WAIT_MAX;
    end
    stall_cycles_d = (pc_hold && stall_cycles_q != '1) ? stall_cycles_q + 32'd1 : stall_cycles_q;
  end
  // state and counters; reset aborts any wait or redirect in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= HZ_RUN;
      red_cnt_q      <= 3'd0;
      wait_cnt_q     <= 16'd0;
      mem_err_q      <= 1'b0;
      stall_cycles_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      red_cnt_q      <= red_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_err_q      <= mem_err_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end
  assign bus.pc_hold      = !rst && pc_hold;
  assign bus.if_id_hold   = !rst && if_id_hold;
  assign bus.id_ex_hold   = !rst && id_ex_hold;
  assign bus.ex_mem_hold  = !rst && ex_mem_hold;
  assign bus.if_id_flush  = rst || if_id_flush;
  assign bus.id_ex_flush  = rst || id_ex_flush;
  assign bus.mem_wb_flush = rst || mem_wb_flush;
  assign bus.mem_err      = !rst && mem_err_q;
  assign bus.state        = rst ? HZ_RUN : state_q;
  assign bus.stall_cycles = rst ? 32'd0 : stall_cycles_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl with REDIRECT_CYCLES=2, MEM_TIMEOUT=3
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;
  typedef struct packed {
    logic       rst;
    logic [6:0] opc;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       br;
    logic       mreq;
    logic       mrdy;
  } stim_t;
  typedef struct packed {
    stim_t      s;
    logic [9:0] e;
  } step_t;
  localparam stim_t IDLE = '0;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_stall = 32'd0;
  step_t step_q[$];
  logic [9:0] exp_q[$];
  hazard_ctrl_if bus ();
  hazard_ctrl #(.REDIRECT_CYCLES(2), .MEM_TIMEOUT(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic stim_t mk(logic r, logic [6:0] o, logic [4:0] d, logic [4:0] a, logic [4:0] b,
                               logic u1, logic u2, logic br, logic mq, logic my);
    return {r, o, d, a, b, u1, u2, br, mq, my};
  endfunction
  function automatic stim_t ev(logic br, logic mq, logic my);
    return mk(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, br, mq, my);
  endfunction
  function automatic logic [9:0] ex(logic [3:0] h, logic [2:0] f, logic er, logic [1:0] st);
    return {h, f, er, st};
  endfunction
  function automatic logic [9:0] obs();
    return {bus.pc_hold, bus.if_id_hold, bus.id_ex_hold, bus.ex_mem_hold,
            bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_flush, bus.mem_err, bus.state};
  endfunction
  task automatic add(stim_t s, logic [9:0] e);
    step_q.push_back({s, e});
  endtask
  task automatic apply(stim_t s);
    rst                 = s.rst;
    bus.opcode_ex       = s.opc;
    bus.rd_addr_ex      = s.rd;
    bus.rs1_addr_id     = s.rs1;
    bus.rs2_addr_id     = s.rs2;
    bus.rs1_used_id     = s.u1;
    bus.rs2_used_id     = s.u2;
    bus.branch_taken_ex = s.br;
    bus.mem_req         = s.mreq;
    bus.mem_ready       = s.mrdy;
  endtask
  task automatic test_reset();
    add(mk(1'b1, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), ex(4'h0, 3'b111, 1'b0, 2'd0));
    add(IDLE, ex(4'h0, 3'b000, 1'b0, 2'd0));
    for (int k = 0; step_q.size() > 0; k++) begin
      step_t t;
      logic [9:0] e;
      t = step_q.pop_front();
      apply(t.s);
      exp_q.push_back(t.e);
      @(negedge clk);
      e = exp_q.pop_front();
      if (t.s.rst) exp_stall = 32'd0;
      checks += 2;
      if (obs() !== e) begin errors++; $display("FAIL reset step %0d outputs got %b want %b", k, obs(), e); end
      if (bus.stall_cycles !== exp_stall) begin errors++; $display("FAIL reset step %0d stall_cycles got %0d want %0d", k, bus.stall_cycles, exp_stall); end
      if (e[9]) exp_stall++;
      @(posedge clk); #1;
    end
  endtask
  task automatic test_load_use();
    add(mk(1'b0, OPC_LOAD, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), ex(4'hC, 3'b010, 1'b0, 2'd0));
    add(IDLE, ex(4'h0, 3'b000, 1'b0, 2'd0));
    add(mk(1'b0, OPC_LOAD, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), ex(4'h0, 3'b000, 1'b0, 2'd0));
    add(mk(1'b0, OPC_LOAD, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), ex(4'h0, 3'b000, 1'b0, 2'd0));
    add(mk(1'b0, OPC_LOAD, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), ex(4'hC, 3'b010, 1'b0, 2'd0));
    add(mk(1'b0, OPC_STORE, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), ex(4'h0, 3'b000, 1'b0, 2'd0));
    add(mk(1'b0, OPC_LOAD, 5'd9, 5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), ex(4'h0, 3'b000, 1'b0, 2'd0));
    add(IDLE, ex(4'h0, 3'b000, 1'b0, 2'd0));
    for (int k = 0; step_q.size() > 0; k++) begin
      step_t t;
      logic [9:0] e;
      t = step_q.pop_front();
      apply(t.s);
      exp_q.push_back(t.e);
      @(negedge clk);
      e = exp_q.pop_front();
      checks += 2;
      if (obs() !== e) begin errors++; $display("FAIL load_use step %0d outputs got %b want %b", k, obs(), e); end
      if (bus.stall_cycles !== exp_stall) begin errors++; $display("FAIL load_use step %0d stall_cycles got %0d want %0d", k, bus.stall_cycles, exp_stall); end
      if (e[9]) exp_stall++;
      @(posedge clk); #1;
    end
  endtask
  task automatic test_redirect();
    add(ev(1'b1, 1'b0, 1'b0), ex(4'h0, 3'b110, 1'b0, 2'd0));
    add(IDLE, ex(4'h0, 3'b100, 1'b0, 2'd1));
    add(IDLE, ex(4'h0, 3'b100, 1'b0, 2'd1));
    add(IDLE, ex(4'h0, 3'b000, 1'b0, 2'd0));
    add(ev(1'b1, 1'b0, 1'b0), ex(4'h0, 3'b110, 1'b0, 2'd0));
    add(IDLE, ex(4'h0, 3'b100, 1'b0, 2'd1));
    add(ev(1'b1, 1'b0, 1'b0), ex(4'h0, 3'b110, 1'b0, 2'd1));
    add(IDLE, ex(4'h0, 3'b100, 1'b0, 2'd1));
    add(IDLE, ex(4'h0, 3'b100, 1'b0, 2'd1));
    add(IDLE, ex(4'h0, 3'b000, 1'b0, 2'd0));
    add(ev(1'b1, 1'b0, 1'b0), ex(4'h0, 3'b110, 1'b0, 2'd0));
    add(ev(1'b0, 1'b1, 1'b0), ex(4'hF, 3'b101, 1'b0, 2'd1));
    add(ev(1'b0, 1'b1, 1'b0), ex(4'hF, 3'b001, 1'b0, 2'd2));
    add(ev(1'b0, 1'b1, 1'b1), ex(4'h0, 3'b000, 1'b0, 2'd2));
    add(IDLE, ex(4'h0, 3'b000, 1'b0, 2'd0));
    for (int k = 0; step_q.size() > 0; k++) begin
      step_t t;
      logic [9:0] e;
      t = step_q.pop_front();
      apply(t.s);
      exp_q.push_back(t.e);
      @(negedge clk);
      e = exp_q.pop_front();
      checks += 2;
      if (obs() !== e) begin errors++; $display("FAIL redirect step %0d outputs got %b want %b", k, obs(), e); end
      if (bus.stall_cycles !== exp_stall) begin errors++; $display("FAIL redirect step %0d stall_cycles got %0d want %0d", k, bus.stall_cycles, exp_stall); end
      if (e[9]) exp_stall++;
      @(posedge clk); #1;
    end
  endtask
  task automatic test_mem_wait();
    add(ev(1'b0, 1'b1, 1'b1), ex(4'h0, 3'b000, 1'b0, 2'd0));
    add(ev(1'b0, 1'b1, 1'b0), ex(4'hF, 3'b001, 1'b0, 2'd0));
    add(ev(1'b0, 1'b1, 1'b0), ex(4'hF, 3'b001, 1'b0, 2'd2));
    add(ev(1'b0, 1'b1, 1'b1), ex(4'h0, 3'b000, 1'b0, 2'd2));
    add(IDLE, ex(4'h0, 3'b000, 1'b0, 2'd0));
    for (int k = 0; step_q.size() > 0; k++) begin
      step_t t;
      logic [9:0] e;
      t = step_q.pop_front();
      apply(t.s);
      exp_q.push_back(t.e);
      @(negedge clk);
      e = exp_q.pop_front();
      checks += 2;
      if (obs() !== e) begin errors++; $display("FAIL mem_wait step %0d outputs got %b want %b", k, obs(), e); end
      if (bus.stall_cycles !== exp_stall) begin errors++; $display("FAIL mem_wait step %0d stall_cycles got %0d want %0d", k, bus.stall_cycles, exp_stall); end
      if (e[9]) exp_stall++;
      @(posedge clk); #1;
    end
  endtask
  task automatic test_simultaneous();
    add(mk(1'b0, OPC_LOAD, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0), ex(4'hF, 3'b001, 1'b0, 2'd0));
    add(mk(1'b0, OPC_LOAD, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0), ex(4'hF, 3'b001, 1'b0, 2'd2));
    add(mk(1'b0, OPC_LOAD, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1), ex(4'h0, 3'b000, 1'b0, 2'd2));
    add(mk(1'b0, OPC_LOAD, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0), ex(4'h0, 3'b110, 1'b0, 2'd0));
    add(IDLE, ex(4'h0, 3'b100, 1'b0, 2'd1));
    add(IDLE, ex(4'h0, 3'b100, 1'b0, 2'd1));
    add(IDLE, ex(4'h0, 3'b000, 1'b0, 2'd0));
    for (int k = 0; step_q.size() > 0; k++) begin
      step_t t;
      logic [9:0] e;
      t = step_q.pop_front();
      apply(t.s);
      exp_q.push_back(t.e);
      @(negedge clk);
      e = exp_q.pop_front();
      checks += 2;
      if (obs() !== e) begin errors++; $display("FAIL simultaneous step %0d outputs got %b want %b", k, obs(), e); end
      if (bus.stall_cycles !== exp_stall) begin errors++; $display("FAIL simultaneous step %0d stall_cycles got %0d want %0d", k, bus.stall_cycles, exp_stall); end
      if (e[9]) exp_stall++;
      @(posedge clk); #1;
    end
  endtask
  task automatic test_timeout();
    add(ev(1'b0, 1'b1, 1'b0), ex(4'hF, 3'b001, 1'b0, 2'd0));
    add(ev(1'b0, 1'b1, 1'b0), ex(4'hF, 3'b001, 1'b0, 2'd2));
    add(ev(1'b0, 1'b1, 1'b0), ex(4'hF, 3'b001, 1'b0, 2'd2));
    add(ev(1'b0, 1'b1, 1'b0), ex(4'hF, 3'b001, 1'b1, 2'd2));
    add(ev(1'b0, 1'b1, 1'b0), ex(4'hF, 3'b001, 1'b1, 2'd2));
    add(ev(1'b0, 1'b1, 1'b1), ex(4'h0, 3'b000, 1'b1, 2'd2));
    add(IDLE, ex(4'h0, 3'b000, 1'b1, 2'd0));
    add(mk(1'b0, OPC_LOAD, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), ex(4'hC, 3'b010, 1'b1, 2'd0));
    for (int k = 0; step_q.size() > 0; k++) begin
      step_t t;
      logic [9:0] e;
      t = step_q.pop_front();
      apply(t.s);
      exp_q.push_back(t.e);
      @(negedge clk);
      e = exp_q.pop_front();
      checks += 2;
      if (obs() !== e) begin errors++; $display("FAIL timeout step %0d outputs got %b want %b", k, obs(), e); end
      if (bus.stall_cycles !== exp_stall) begin errors++; $display("FAIL timeout step %0d stall_cycles got %0d want %0d", k, bus.stall_cycles, exp_stall); end
      if (e[9]) exp_stall++;
      @(posedge clk); #1;
    end
  endtask
  task automatic test_reset_mid_wait();
    add(ev(1'b0, 1'b1, 1'b0), ex(4'hF, 3'b001, 1'b1, 2'd0));
    add(ev(1'b0, 1'b1, 1'b0), ex(4'hF, 3'b001, 1'b1, 2'd2));
    add(mk(1'b1, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), ex(4'h0, 3'b111, 1'b0, 2'd0));
    add(ev(1'b0, 1'b1, 1'b0), ex(4'hF, 3'b001, 1'b0, 2'd0));
    add(ev(1'b0, 1'b1, 1'b1), ex(4'h0, 3'b000, 1'b0, 2'd2));
    add(IDLE, ex(4'h0, 3'b000, 1'b0, 2'd0));
    for (int k = 0; step_q.size() > 0; k++) begin
      step_t t;
      logic [9:0] e;
      t = step_q.pop_front();
      apply(t.s);
      exp_q.push_back(t.e);
      @(negedge clk);
      e = exp_q.pop_front();
      if (t.s.rst) exp_stall = 32'd0;
      checks += 2;
      if (obs() !== e) begin errors++; $display("FAIL reset_mid_wait step %0d outputs got %b want %b", k, obs(), e); end
      if (bus.stall_cycles !== exp_stall) begin errors++; $display("FAIL reset_mid_wait step %0d stall_cycles got %0d want %0d", k, bus.stall_cycles, exp_stall); end
      if (e[9]) exp_stall++;
      @(posedge clk); #1;
    end
  endtask
  initial begin
    apply(mk(1'b1, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_simultaneous();
    test_timeout();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RV32 core. It decides per cycle which pipeline registers hold and which ones flush. It covers load-use hazards that forwarding cannot resolve, taken-branch/jump redirects with an extended fetch flush, and data-memory wait states. It sits beside the operand-forwarding logic and drives the hold/flush enables of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

## Interface
Parameters:
- REDIRECT_CYCLES, 1: extra cycles IF/ID stays flushed after a redirect (instruction-memory latency); range 0..7.
- MEM_TIMEOUT, 255: max MEM_WAIT cycles before mem_err is set; range 1..65535.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode_ex  in  7  opcode of the instruction in EX.
- rd_addr_ex  in  5  destination register of the instruction in EX.
- rs1_addr_id, rs2_addr_id  in  5 each  source registers of the instruction in ID.
- rs1_used_id, rs2_used_id  in  1 each  ID instruction actually reads rs1/rs2.
- branch_taken_ex  in  1  EX resolved a taken branch/JAL/JALR this cycle.
- mem_req  in  1  MEM stage has a load/store in flight.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_hold, if_id_hold, id_ex_hold, ex_mem_hold  out  1 each  hold the register (no update).
- if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  load a bubble (NOP, rd=0).
- mem_err  out  1  sticky: a MEM_WAIT exceeded MEM_TIMEOUT; cleared only by rst.
- state  out  2  current FSM state, for debug.
- stall_cycles  out  32  saturating count of cycles with pc_hold=1.

## Operation
- FSM states: RUN=0, REDIRECT=1, MEM_WAIT=2. Encoding 3 is unused and returns to RUN next cycle.
- Load-use detect (combinational, active in RUN only):
  - Condition: opcode_ex==OPC_LOAD, rd_addr_ex!=0, and (rs1_used_id and rs1_addr_id==rd_addr_ex, or rs2_used_id and rs2_addr_id==rd_addr_ex).
  - Response: pc_hold=1, if_id_hold=1, id_ex_flush=1 for exactly that cycle. No state change.
- Priority among events in a cycle: mem wait > redirect > load-use.
- RUN:
  - mem_req and !mem_ready → assert pc/if_id/id_ex/ex_mem holds and mem_wb_flush this cycle; go to MEM_WAIT.
  - Else branch_taken_ex → if_id_flush=1 and id_ex_flush=1 this cycle. Go to REDIRECT if REDIRECT_CYCLES>0, else stay in RUN.
- MEM_WAIT:
  - All four holds and mem_wb_flush stay asserted while mem_ready=0.
  - Wait counter increments each cycle. When it reaches MEM_TIMEOUT, mem_err is set and the FSM keeps waiting.
  - On mem_ready=1: release holds that same cycle and return to RUN.
  - A branch_taken_ex seen during MEM_WAIT is ignored. EX is held, so the branch is re-presented and acted on in RUN.
- REDIRECT:
  - if_id_flush=1 and a down-counter loaded with REDIRECT_CYCLES decrements each cycle.
  - Exit to RUN when the counter reaches 0.
  - A new branch_taken_ex reloads the counter.
  - mem_req with !mem_ready preempts to MEM_WAIT; the remaining redirect count is discarded, and if_id_flush stays asserted on the MEM_WAIT entry cycle.
- stall_cycles increments when pc_hold=1 and saturates at 0xFFFF_FFFF.

## Timing
- Reset: while rst=1, state=RUN, counters=0, mem_err=0, stall_cycles=0, all holds=0, and if_id_flush=id_ex_flush=mem_wb_flush=1. This pipes bubbles in.
- Reset mid-MEM_WAIT or mid-REDIRECT aborts the operation; the first cycle after rst falls is RUN.
- Holds and flushes are combinational from the current state and inputs: zero-cycle latency to the pipeline registers.
- Load-use costs exactly 1 bubble.
- Taken branch costs 2 + REDIRECT_CYCLES bubbles.
- An N-cycle memory wait stalls the PC for N cycles.
- A hold and a flush on the same register are never both asserted. If both conditions arise, the hold wins, except in the MEM_WAIT entry case above, where IF/ID is both held and flushed and the flush wins.

## Structure
- The shared core defines header holds:
  - OPC_LOAD, OPC_BRANCH, OPC_STORE, OPC_JAL, OPC_JALR, already used by the forwarding logic.
  - The new state encodings HZ_RUN, HZ_REDIRECT, HZ_MEM_WAIT.
- One sub-module, load_use_detect: purely combinational comparator producing the single-bit hazard flag.
- The FSM, counters and output decode live in hazard_ctrl.

## Test plan
- Load-use: opcode_ex=OPC_LOAD, rd_addr_ex=5, rs2_addr_id=5, rs2_used_id=1 for one cycle → pc_hold=if_id_hold=id_ex_flush=1 for one cycle; stall_cycles 0→1. Repeat with rd_addr_ex=0 or rs2_used_id=0 → no hold.
- Redirect, REDIRECT_CYCLES=2: branch_taken_ex pulse → id_ex_flush for 1 cycle, if_id_flush for 3 cycles, state sequence 0,1,1,0.
- Memory wait: mem_req=1, mem_ready=0 for 4 cycles, then 1 → holds high for 4 cycles, released on the ready cycle; stall_cycles +=4.
- Simultaneous: mem wait, taken branch and load-use in the same cycle → MEM_WAIT behaviour only. Branch flush fires the cycle after mem_ready.
- Timeout, MEM_TIMEOUT=3: mem_ready held 0 for 5 cycles → mem_err=1 from the 4th cycle; mem_err stays 1 after the wait ends until rst.
- Reset mid-MEM_WAIT: rst for 1 cycle → all three flushes=1 and holds=0 during rst; state=RUN and mem_err=0 afterwards.
